// File: rtl/ahb_dffram_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_dffram_bridge
//  Purpose  : AHB-Lite slave in front of a single DFFRAM macro. Turns AHB
//             address/data phases into single-cycle macro accesses, builds
//             byte-lane write enables, inserts one wait state when a read
//             address phase collides with a write data phase, and returns
//             the two-cycle ERROR response for unsupported transfers.
//  Ports    :
//    CLK        in   clock, rising edge, shared with the macro
//    RESETn     in   asynchronous active-low reset
//    HSEL       in   slave select
//    HADDR      in   byte address (low AW bits reach the macro)
//    HTRANS     in   transfer type, NONSEQ/SEQ are real transfers
//    HWRITE     in   1 = write
//    HSIZE      in   0 = byte, 1 = half, 2 = word, others rejected
//    HWDATA     in   write data, data phase
//    HREADY     in   bus ready
//    HREADYOUT  out  slave ready
//    HRESP      out  0 = OKAY, 1 = ERROR
//    HRDATA     out  read data (meaningful in the read data phase)
//    RAM_EN     out  macro enable
//    RAM_WE     out  macro byte write enables
//    RAM_A      out  macro byte address
//    RAM_Di     out  macro write data
//    RAM_Do     in   macro registered read data
//  Revision : 1.0  initial release
// ============================================================================
module ahb_dffram_bridge #(
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [31:0]   RAM_Di,
    input  logic [31:0]   RAM_Do
);

    localparam logic [2:0] C_SIZE_BYTE = 3'd0;
    localparam logic [2:0] C_SIZE_HALF = 3'd1;
    localparam logic [2:0] C_SIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_RDATA = 3'd2,
        ST_RPEND = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]    wr_mask_q, wr_mask_d;
    logic [AW-1:0] rd_pend_addr_q, rd_pend_addr_d;

    logic          w_acc;
    logic          w_err_req;
    logic [3:0]    w_mask;

    // Bits that carry no information for this slave.
    logic          w_unused_ok;
    assign w_unused_ok = &{1'b0, HADDR[31:AW], HTRANS[0]};

    // Gating with RESETn keeps the macro idle while reset is held, even if
    // the bus still presents a transfer.
    assign w_acc = HSEL & HREADY & HTRANS[1] & RESETn;

    assign w_err_req = (HSIZE > C_SIZE_WORD)
                     | ((HSIZE == C_SIZE_HALF) & HADDR[0])
                     | ((HSIZE == C_SIZE_WORD) & (HADDR[1:0] != 2'b00));

    always_comb begin
        w_mask = 4'b1111;
        case (HSIZE)
            C_SIZE_BYTE: w_mask = 4'b0001 << HADDR[1:0];
            C_SIZE_HALF: w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default:     w_mask = 4'b1111;
        endcase
    end

    // Write data and read data pass straight through; HRDATA is only
    // looked at by the master during a read data phase.
    assign RAM_Di = HWDATA;
    assign HRDATA = RAM_Do;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q        <= ST_IDLE;
            wr_addr_q      <= '0;
            wr_mask_q      <= '0;
            rd_pend_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            wr_mask_q      <= wr_mask_d;
            rd_pend_addr_q <= rd_pend_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        wr_mask_d      = wr_mask_q;
        rd_pend_addr_d = rd_pend_addr_q;
        HREADYOUT      = 1'b1;
        HRESP          = 1'b0;
        RAM_EN         = 1'b0;
        RAM_WE         = 4'b0000;
        RAM_A          = '0;

        // Data-phase side: what the current state owes the macro/bus.
        case (state_q)
            ST_WDATA: begin
                RAM_EN = 1'b1;
                RAM_WE = wr_mask_q;
                RAM_A  = wr_addr_q;
            end
            ST_RPEND: begin
                // Macro was busy with the write last cycle; issue the
                // deferred read now and hold the bus for it.
                RAM_EN    = 1'b1;
                RAM_A     = rd_pend_addr_q;
                HREADYOUT = 1'b0;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
            end
            default: begin
            end
        endcase

        // Address-phase side. RPEND and ERR1 stall the bus, so no new
        // address phase can complete in those states.
        if (state_q == ST_RPEND) begin
            state_d = ST_RDATA;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (!w_acc) begin
            state_d = ST_IDLE;
        end else if (w_err_req) begin
            state_d = ST_ERR1;
        end else if (HWRITE) begin
            wr_addr_d = HADDR[AW-1:0];
            wr_mask_d = w_mask;
            state_d   = ST_WDATA;
        end else if (state_q == ST_WDATA) begin
            rd_pend_addr_d = HADDR[AW-1:0];
            state_d        = ST_RPEND;
        end else begin
            // Port is free: launch the read in its own address phase so
            // the registered macro output lands in the data phase.
            RAM_EN  = 1'b1;
            RAM_WE  = 4'b0000;
            RAM_A   = HADDR[AW-1:0];
            state_d = ST_RDATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_dffram_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_dffram_bridge
//  Purpose  : Self-checking bench for ahb_dffram_bridge with a DFFRAM model,
//             a transaction-level reference model and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ahb_dffram_bridge;

    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = '0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE = 3'd0;
    logic [31:0]   HWDATA = '0;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          RAM_EN;
    logic [3:0]    RAM_WE;
    logic [AW-1:0] RAM_A;
    logic [31:0]   RAM_Di;
    logic [31:0]   RAM_Do = '0;

    assign HREADY = HREADYOUT;

    always #5 CLK = ~CLK;

    ahb_dffram_bridge #(.AW(AW)) dut (
        .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A),
        .RAM_Di(RAM_Di), .RAM_Do(RAM_Do)
    );

    // ---------------- DFFRAM macro model ----------------
    logic [31:0] ram [0:63] = '{default: 32'h0};
    always @(posedge CLK) begin
        if (RAM_EN) begin
            RAM_Do <= ram[RAM_A[AW-1:2]];
            for (int b = 0; b < 4; b++)
                if (RAM_WE[b]) ram[RAM_A[AW-1:2]][b*8 +: 8] <= RAM_Di[b*8 +: 8];
        end else begin
            RAM_Do <= '0;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    localparam int K_NONE = 0, K_RD = 1, K_WR = 2, K_ERR = 3;
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    int          m_kind  = K_NONE;
    logic [31:0] m_addr  = '0;
    logic [3:0]  m_mask  = '0;
    int          m_wait  = 0;     // wait states left in a read data phase
    int          m_phase = 0;     // 0 = first ERROR cycle, 1 = second
    logic        exp_ready = 1'b1;

    function automatic bit f_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] f_mask(input logic [31:0] a, input logic [2:0] s);
        logic [3:0] one;
        one = 4'b0001;
        if (s == 3'd0) return one << a[1:0];
        if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // A transfer completes on an edge where the slave was ready; a read
    // whose address phase ends while a write data phase completes must
    // wait one cycle because the macro port was used by that write.
    always @(posedge CLK) begin
        if (!RESETn) begin
            m_kind  <= K_NONE;
            m_wait  <= 0;
            m_phase <= 0;
        end else if (exp_ready) begin
            if (m_kind == K_WR)
                for (int b = 0; b < 4; b++)
                    if (m_mask[b]) ref_mem[m_addr[AW-1:2]][b*8 +: 8] <= HWDATA[b*8 +: 8];
            if (HSEL && HTRANS[1]) begin
                m_addr <= HADDR;
                if (f_err(HADDR, HSIZE)) begin
                    m_kind  <= K_ERR;
                    m_phase <= 0;
                end else if (HWRITE) begin
                    m_kind <= K_WR;
                    m_mask <= f_mask(HADDR, HSIZE);
                end else begin
                    m_kind <= K_RD;
                    m_wait <= (m_kind == K_WR) ? 1 : 0;
                end
            end else begin
                m_kind <= K_NONE;
            end
        end else begin
            if (m_kind == K_RD && m_wait > 0) m_wait <= m_wait - 1;
            if (m_kind == K_ERR) m_phase <= 1;
        end
    end

    // ---------------- checking ----------------
    int n_run = 0, n_fail = 0;
    int stall_cnt = 0, resp_cnt = 0, en_cnt = 0;
    logic [3:0]  we_log[$];
    logic [31:0] rd_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called once per cycle at the falling edge.
    task automatic compare_cycle();
        logic e_ready, e_resp, e_en;
        logic [3:0]  e_we;
        logic [31:0] e_a;
        if (!RESETn) begin
            chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
            chk("rst_hresp",     {31'd0, HRESP},     32'd0);
            chk("rst_ram_en",    {31'd0, RAM_EN},    32'd0);
            chk("rst_ram_we",    {28'd0, RAM_WE},    32'd0);
            return;
        end
        e_ready = 1'b1; e_resp = 1'b0; e_en = 1'b0; e_we = 4'b0; e_a = '0;
        if (m_kind == K_WR) begin
            e_en = 1'b1; e_we = m_mask; e_a = m_addr;
        end else if (m_kind == K_RD && m_wait != 0) begin
            e_ready = 1'b0; e_en = 1'b1; e_a = m_addr;
        end else if (m_kind == K_ERR) begin
            e_resp = 1'b1; e_ready = (m_phase != 0);
        end
        if (e_ready && HSEL && HTRANS[1] && !HWRITE && !f_err(HADDR, HSIZE) && m_kind != K_WR) begin
            e_en = 1'b1; e_a = HADDR;
        end
        exp_ready = e_ready;
        chk("hreadyout", {31'd0, HREADYOUT}, {31'd0, e_ready});
        chk("hresp",     {31'd0, HRESP},     {31'd0, e_resp});
        chk("ram_en",    {31'd0, RAM_EN},    {31'd0, e_en});
        chk("ram_we",    {28'd0, RAM_WE},    {28'd0, e_we});
        if (e_en) chk("ram_a", {24'd0, RAM_A}, {24'd0, e_a[AW-1:0]});
        if (m_kind == K_RD && e_ready) chk("hrdata", HRDATA, ref_mem[m_addr[AW-1:2]]);
        if (!HREADYOUT) stall_cnt++;
        if (HRESP) resp_cnt++;
        if (RAM_EN) en_cnt++;
        if (RAM_WE != 4'b0) we_log.push_back(RAM_WE);
    endtask

    // ---------------- bus master ----------------
    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    logic        d_wr = 1'b0, d_rd = 1'b0;
    logic [31:0] d_wdata = '0;

    function automatic op_t W(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        op_t o; o.sel = 1'b1; o.trans = 2'b10; o.write = 1'b1; o.addr = a; o.size = s; o.wdata = d;
        return o;
    endfunction
    function automatic op_t R(input logic [31:0] a, input logic [2:0] s);
        op_t o; o.sel = 1'b1; o.trans = 2'b10; o.write = 1'b0; o.addr = a; o.size = s; o.wdata = '0;
        return o;
    endfunction
    function automatic op_t IDL();
        op_t o; o.sel = 1'b0; o.trans = 2'b00; o.write = 1'b0; o.addr = '0; o.size = 3'd0; o.wdata = '0;
        return o;
    endfunction

    task automatic drive_op(input op_t op, output bit taken);
        HSEL = op.sel; HTRANS = op.trans; HWRITE = op.write;
        HADDR = op.addr; HSIZE = op.size;
        HWDATA = d_wr ? d_wdata : 32'h0;
        @(negedge CLK);
        compare_cycle();
        taken = HREADYOUT;
        if (HREADYOUT && d_rd) rd_log.push_back(HRDATA);
        @(posedge CLK); #1;
        if (taken) begin
            d_wr    = op.sel && op.trans[1] && op.write  && !f_err(op.addr, op.size);
            d_rd    = op.sel && op.trans[1] && !op.write && !f_err(op.addr, op.size);
            d_wdata = op.wdata;
        end
    endtask

    task automatic run_ops(input op_t q[$]);
        bit taken;
        int guard;
        q.push_back(IDL());
        q.push_back(IDL());
        foreach (q[i]) begin
            guard = 0;
            do begin
                drive_op(q[i], taken);
                guard++;
            end while (!taken && guard < 8);
            if (!taken) chk("stall_bound", 32'd0, 32'd1);
        end
    endtask

    int s0, r0, e0, w0;
    task automatic snap();
        s0 = stall_cnt; r0 = resp_cnt; e0 = en_cnt; w0 = we_log.size();
    endtask
    function automatic logic [31:0] rd_last(input int back);
        return rd_log[rd_log.size() - 1 - back];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit t;
        // Reset
        repeat (2) begin
            @(negedge CLK); compare_cycle();
            @(posedge CLK); #1;
        end
        RESETn = 1'b1;

        // 1: word write then read with an idle cycle between
        snap();
        run_ops('{W(32'h10, 3'd2, 32'hDEADBEEF), IDL(), R(32'h10, 3'd2)});
        chk("t1_we",    {28'd0, we_log[w0]}, 32'h0000000F);
        chk("t1_rdata", rd_last(0), 32'hDEADBEEF);
        chk("t1_stall", stall_cnt - s0, 32'd0);

        // 2: byte + half writes over a cleared word
        run_ops('{W(32'h10, 3'd2, 32'h0)});
        snap();
        run_ops('{W(32'h13, 3'd0, 32'hAA000000), W(32'h10, 3'd1, 32'h00005555), IDL(), R(32'h10, 3'd2)});
        chk("t2_we0",   {28'd0, we_log[w0]},     32'h00000008);
        chk("t2_we1",   {28'd0, we_log[w0 + 1]}, 32'h00000003);
        chk("t2_rdata", rd_last(0), 32'hAA005555);
        chk("t2_stall", stall_cnt - s0, 32'd0);

        // 3: write immediately followed by read of the same word
        snap();
        run_ops('{W(32'h20, 3'd2, 32'h12345678), R(32'h20, 3'd2)});
        chk("t3_stall", stall_cnt - s0, 32'd1);
        chk("t3_rdata", rd_last(0), 32'h12345678);

        // 4: back-to-back reads
        run_ops('{W(32'h0, 3'd2, 32'd1), W(32'h4, 3'd2, 32'd2), W(32'h8, 3'd2, 32'd3), W(32'hC, 3'd2, 32'd4)});
        snap();
        run_ops('{R(32'h0, 3'd2), R(32'h4, 3'd2), R(32'h8, 3'd2), R(32'hC, 3'd2)});
        chk("t4_rd0", rd_last(3), 32'd1);
        chk("t4_rd1", rd_last(2), 32'd2);
        chk("t4_rd2", rd_last(1), 32'd3);
        chk("t4_rd3", rd_last(0), 32'd4);
        chk("t4_stall", stall_cnt - s0, 32'd0);

        // 5: misaligned word read, then HSIZE=3
        snap();
        run_ops('{R(32'h02, 3'd2)});
        chk("t5a_stall", stall_cnt - s0, 32'd1);
        chk("t5a_resp",  resp_cnt - r0,  32'd2);
        chk("t5a_en",    en_cnt - e0,    32'd0);
        snap();
        run_ops('{R(32'h00, 3'd3)});
        chk("t5b_stall", stall_cnt - s0, 32'd1);
        chk("t5b_resp",  resp_cnt - r0,  32'd2);
        chk("t5b_en",    en_cnt - e0,    32'd0);

        // 6: reset pulse during the deferred-read wait state
        drive_op(W(32'h30, 3'd2, 32'hCAFEF00D), t);
        drive_op(R(32'h30, 3'd2), t);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0;
        @(negedge CLK);
        compare_cycle();
        chk("t6_rpend_wait", {31'd0, HREADYOUT}, 32'd0);
        #2 RESETn = 1'b0;
        #1;
        chk("t6_rst_ready", {31'd0, HREADYOUT}, 32'd1);
        chk("t6_rst_en",    {31'd0, RAM_EN},    32'd0);
        snap();
        @(posedge CLK); #1;
        RESETn = 1'b1;
        d_wr = 1'b0; d_rd = 1'b0;
        run_ops('{IDL(), R(32'h30, 3'd2)});
        chk("t6_no_write", we_log.size() - w0, 32'd0);
        chk("t6_rdata", rd_last(0), 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_dffram_bridge.md
Name: ahb_dffram_bridge

Overview:
AHB-Lite slave that fronts one DFFRAM macro and drives its CLK/WE[3:0]/EN/Di/Do/A port.
- Converts AHB address and data phases into single-cycle macro accesses.
- Generates byte-lane write enables from HSIZE and HADDR[1:0].
- Resolves the write-data-phase versus read-address-phase port conflict with one wait state.
- Returns the two-cycle AHB ERROR response for unsupported transfers.

Parameters:
AW, 8, macro byte-address width; RAM_A = HADDR[AW-1:0], and the macro indexes words internally.

Ports:
CLK  in  1  clock, rising edge; also drives the macro
RESETn  in  1  reset, asynchronous, active-low
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  transfer type; only NONSEQ (10) and SEQ (11) are valid transfers
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = half, 2 = word
HWDATA  in  32  write data, valid in the data phase
HREADY  in  1  bus ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data
RAM_EN  out  1  macro enable
RAM_WE  out  4  macro byte write enables
RAM_A  out  AW  macro byte address
RAM_Di  out  32  macro write data
RAM_Do  in  32  macro read data; registered; 0 after a cycle with EN=0

Behaviour:
- Accept condition: acc = HSEL & HREADY & HTRANS[1]. When acc=0, no state is captured from the address phase.
- Error condition: err_req = HSIZE>2, or HSIZE==1 & HADDR[0], or HSIZE==2 & HADDR[1:0]!=0.
- Byte mask by HSIZE:
  - byte: 1<<HADDR[1:0]
  - half: HADDR[1] ? 1100 : 0011
  - word: 1111
- Registers: state, wr_addr, wr_mask, rd_pend_addr.
- States: IDLE, WDATA, RDATA, RPEND, ERR1, ERR2.
- Reset (asynchronous, RESETn=0) gives state=IDLE, HREADYOUT=1, HRESP=0, RAM_EN=0, RAM_WE=0, all address/mask registers 0.
- Address-phase read, accepted with no write data phase in progress:
  - Same cycle: RAM_EN=1, RAM_WE=0, RAM_A=HADDR[AW-1:0].
  - Next state RDATA.
- RDATA:
  - HRDATA=RAM_Do, HREADYOUT=1, HRESP=0. Zero wait states.
  - A new accepted read in this cycle issues its macro read in the same cycle (pipelined).
- Address-phase write, accepted:
  - Captures wr_addr and wr_mask; next state WDATA.
  - The address-phase cycle drives no macro write.
- WDATA:
  - RAM_EN=1, RAM_WE=wr_mask, RAM_A=wr_addr, RAM_Di=HWDATA.
  - HREADYOUT=1.
- Accepted read during WDATA:
  - The macro port is busy, so capture rd_pend_addr; next state RPEND.
- RPEND (first data-phase cycle of the read):
  - RAM_EN=1, RAM_A=rd_pend_addr, HREADYOUT=0.
  - The bus address is not sampled because HREADY=0.
  - Next state RDATA.
- Accepted write during WDATA:
  - Recaptures wr_addr and wr_mask and stays in WDATA.
  - Back-to-back writes run with no wait states.
- Accepted transfer with err_req:
  - No macro access; next state ERR1.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - The next state after ERR2 follows normal address-phase decode.
- IDLE/BUSY transfer or HSEL=0 in the address phase: next state IDLE, HREADYOUT=1, HRESP=0.
- RAM_EN=0 and RAM_WE=0 whenever no access is scheduled. HRDATA is only meaningful in RDATA.
- Read-after-write to the same address is coherent:
  - The write lands in the WDATA cycle.
  - The read is issued in RPEND, one edge later.
- Reset asserted mid-transfer: the outstanding transfer is abandoned, the pending read is dropped, and no macro write occurs after reset deasserts until a new accepted write.

Test Plan:
- Write word 0xDEADBEEF at 0x10, then read 0x10 with an idle cycle between → write data phase has RAM_WE=1111; read data phase returns HRDATA=0xDEADBEEF with zero wait states.
- Byte write 0xAA at 0x13, then half write 0x5555 at 0x10, over initial 0x00000000 → word reads 0xAA005555; RAM_WE=1000, then 0011.
- Write 0x12345678 at 0x20 immediately followed by a read of 0x20 → HREADYOUT=0 for exactly one cycle in the read data phase; HRDATA=0x12345678.
- Four back-to-back reads of 0x0, 0x4, 0x8, 0xC (preloaded 1, 2, 3, 4) → HRDATA=1, 2, 3, 4 on consecutive cycles; HREADYOUT held 1.
- Word read at 0x02, and separately HSIZE=3 → each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles, and RAM_EN stays 0.
- RESETn pulsed low during an RPEND wait → HREADYOUT=1 and RAM_EN=0 immediately, with no spurious write; a subsequent read returns the pre-reset contents.
